deinterleaver_conv: RTL
=======================

DEINTERLEAVER_CONV -- requirements
Module: deinterleaver_conv

Interface
REQ-001 Parameter N_BRANCH, default 12, number of commutator branches.
REQ-002 Parameter M, default 17, unit delay depth in bytes per branch step.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  data_in and sync_in are valid this cycle; one byte is accepted per valid cycle.
REQ-006 Port sync_in  input  1  marks data_in as a packet sync byte; qualified by in_valid.
REQ-007 Port data_in  input  8  interleaved byte stream.
REQ-008 Port out_valid  output  1  data_out is valid.
REQ-009 Port data_out  output  8  deinterleaved byte.
REQ-010 Port branch_out  output  4  commutator branch that produced data_out.
REQ-011 Port lock  output  1  commutator is aligned to the sync position.
REQ-012 Port primed  output  1  all delay lines hold valid data since the last realignment.

Function
REQ-013 Commutator counter br in 0..N_BRANCH-1 selects the branch for each accepted byte and advances by 1 per accepted byte, wrapping N_BRANCH-1 -> 0; it holds when in_valid=0.
REQ-014 Branch j SHALL delay its bytes by (N_BRANCH-1-j)*M accepted-on-branch-j bytes; branch N_BRANCH-1 has zero delay. This is the exact inverse of the interleaver, where branch j delays by j*M.
REQ-015 A branch delay line shifts only on cycles where in_valid=1 and br==j; all other branches hold.
REQ-016 The output is registered: out_valid, data_out and branch_out are updated one cycle after the accepting cycle. out_valid=0 on cycles following in_valid=0, and data_out holds its last value.
REQ-017 Realign: when in_valid=1, sync_in=1 and br!=0, the byte is treated as branch 0. br then becomes 1 in the next cycle, lock clears, sync_cnt clears and primed clears.
REQ-018 When in_valid=1, sync_in=1 and br==0, sync_cnt (2-bit) increments and saturates at 3; lock=1 when sync_cnt==3.
REQ-019 Realignment does not flush the delay-line contents; stale bytes are flagged only through primed=0.
REQ-020 fill_cnt counts accepted bytes up to N_BRANCH*(N_BRANCH-1)*M (2244 at the defaults) and saturates there. primed=1 at saturation. A realign clears fill_cnt.
REQ-021 When in_valid is continuous, end-to-end delay through the interleaver plus this block is N_BRANCH*(N_BRANCH-1)*M accepted bytes plus 1 cycle of register latency.
REQ-022 sync_in while in_valid=0 is ignored.

Reset
REQ-023 While reset=0, all of the following are forced to 0 immediately and asynchronously: br, sync_cnt, fill_cnt, lock, primed, out_valid, data_out, branch_out, and every delay-line stage.
REQ-024 Reset mid-stream discards all buffered bytes. The first valid byte after reset release is branch 0.

Structure
REQ-025 A shared package holds DEINT_N_BRANCH=12, DEINT_M=17, the byte width 8, and the derived constant DEINT_TOTAL_DELAY=2244.
REQ-026 One sub-module, deint_delay_line, is parameterised by depth in bytes, with ports clk, reset, shift_en, data_in and data_out. Depth 0 is a pass-through.
REQ-027 The top level instantiates N_BRANCH deint_delay_line instances through a generate loop and holds a registered output multiplexer.

Verification
REQ-028 Reset check: hold reset=0 for 5 cycles with in_valid=1 toggling -> out_valid=0, data_out=0x00, lock=0, primed=0 throughout.
REQ-029 Zero-delay branch: a continuous stream where the byte on branch 11 is 0xA5 -> data_out=0xA5 with branch_out=11 one cycle later.
REQ-030 Round trip: 4000 random bytes through the matching 12x17 interleaver model, then this block -> byte k out equals byte k-2244 in, for every k>=2244; primed rises after exactly 2244 accepted bytes.
REQ-031 Lock: sync_in=1 (data 0x47) every 204 accepted bytes at br==0 -> lock=1 on the third sync and stays 1.
REQ-032 Realign: sync_in=1 arrives at br=5 -> the next byte goes to branch 1, lock=0, primed=0, fill_cnt restarts from 0.
REQ-033 Gapped input: in_valid at 50% random duty -> output sequence identical to the continuous-stream case; out_valid pulses only one cycle after accepted bytes.

Source files
------------

// File: rtl/deinterleaver_conv_pkg.sv
// Shared constants for the convolutional deinterleaver: geometry of the
// commutator and the derived end-to-end fill depth.
package deinterleaver_conv_pkg;

    localparam int DEINT_N_BRANCH    = 12;
    localparam int DEINT_M           = 17;
    localparam int DEINT_BYTE_W      = 8;
    localparam int DEINT_TOTAL_DELAY = DEINT_N_BRANCH * (DEINT_N_BRANCH - 1) * DEINT_M;

    // Branch j is the inverse of interleaver branch j, so it delays the remainder.
    function automatic int branch_depth(input int n_branch, input int m, input int j);
        return (n_branch - 1 - j) * m;
    endfunction

endpackage

// File: rtl/deinterleaver_conv_delay_line.sv
// Byte-wide shift register that advances only when its branch is selected.
// A depth of zero degenerates to a wire.
module deint_delay_line
    import deinterleaver_conv_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    shift_en,
    input  logic [DEINT_BYTE_W-1:0] data_in,
    output logic [DEINT_BYTE_W-1:0] data_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, reset, shift_en};
            assign data_out  = data_in;
        end else begin : g_shift
            logic [DEINT_BYTE_W-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else if (shift_en) begin
                    stage[0] <= data_in;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            // Oldest byte leaves on the same cycle the new byte enters.
            assign data_out = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/deinterleaver_conv.sv
// Convolutional deinterleaver: commutator over N_BRANCH delay lines with sync
// realignment, lock tracking and a fill counter that reports when lines are primed.
module deinterleaver_conv
    import deinterleaver_conv_pkg::*;
#(
    parameter int N_BRANCH = DEINT_N_BRANCH,
    parameter int M        = DEINT_M
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    sync_in,
    input  logic [DEINT_BYTE_W-1:0] data_in,
    output logic                    out_valid,
    output logic [DEINT_BYTE_W-1:0] data_out,
    output logic [3:0]              branch_out,
    output logic                    lock,
    output logic                    primed
);

    localparam int                 TOTAL    = N_BRANCH * (N_BRANCH - 1) * M;
    localparam int                 FILL_W   = $clog2(TOTAL + 1);
    localparam logic [3:0]         LAST_BR  = 4'(N_BRANCH - 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(TOTAL);

    // Stream protocol: no backpressure. Every cycle with in_valid=1 consumes one
    // byte; out_valid=1 exactly one cycle after each consumed byte.
    logic [3:0]              br;
    logic [3:0]              eff_br;
    logic                    realign;
    logic [1:0]              sync_cnt;
    logic [FILL_W-1:0]       fill_cnt;
    logic [DEINT_BYTE_W-1:0] line_out [N_BRANCH];

    // A sync byte always belongs to branch 0, whatever the commutator says.
    assign eff_br  = (in_valid && sync_in) ? 4'd0 : br;
    assign realign = in_valid && sync_in && (br != 4'd0);

    generate
        for (genvar j = 0; j < N_BRANCH; j++) begin : g_branch
            deint_delay_line #(
                .DEPTH(branch_depth(N_BRANCH, M, j))
            ) u_line (
                .clk      (clk),
                .reset    (reset),
                .shift_en (in_valid && (eff_br == 4'(j))),
                .data_in  (data_in),
                .data_out (line_out[j])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br         <= '0;
            sync_cnt   <= '0;
            fill_cnt   <= '0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            branch_out <= '0;
        end else if (in_valid) begin
            br         <= (eff_br == LAST_BR) ? 4'd0 : eff_br + 4'd1;
            out_valid  <= 1'b1;
            data_out   <= line_out[eff_br];
            branch_out <= eff_br;
            if (realign) begin
                sync_cnt <= '0;
                fill_cnt <= '0;
            end else begin
                if (sync_in && (sync_cnt != 2'd3)) sync_cnt <= sync_cnt + 2'd1;
                if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign lock   = (sync_cnt == 2'd3);
    assign primed = (fill_cnt == FILL_MAX);

endmodule
